video_out_reader: RTL and testbench

Wishbone-master frame reader directly downstream of the video input stage. It fetches the stored 8-bit grayscale frame from RAM in 32-byte bursts of 32-bit words and buffers them in a byte FIFO. It regenerates the frame_valid / line_valid / pixel stream with programmable blanking for the display side.

---
 rtl/video_out_reader.sv | 231 +++++++++++++++++++++++
 tb/tb_video_out_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_out_reader.sv
// video_out_reader
//
// Reads a stored 8-bit grayscale frame from RAM over a Wishbone master port,
// one BLOCK_SIZE-byte burst of 32-bit words at a time, into a byte FIFO. A
// free-running timing generator pops the FIFO and regenerates frame_valid /
// line_valid / pixel_out with programmable horizontal and vertical blanking.
//
// Ports
//   p_clk, p_reset         single clock, asynchronous active-high reset
//   frame_base(_valid)     strobe loads the pending frame base address
//   frame_valid            high during active lines
//   line_valid             high during active pixel slots
//   pixel_out              pixel value, meaningful while line_valid is high
//   underflow              one-cycle pulse when an active slot finds FIFO empty
//   p_wb_*                 Wishbone classic master (read only)
//   fetch_state            current fetch FSM state, for observation
//
// Wishbone handshake: a word transfer is offered while CYC and STB are both
// high with ADR stable; it completes in the cycle the slave raises ACK or ERR
// (ERR wins if both are high, and then the word is taken as zero). CYC/STB stay
// high across all words of one block and drop the cycle after the last word.

module video_out_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_BLANK    = 160,
  parameter int V_BLANK    = 40,
  parameter int PIX_DIV    = 4,
  parameter int BLOCK_SIZE = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic [31:0] frame_base,
  input  logic        frame_base_valid,
  output logic        frame_valid,
  output logic        line_valid,
  output logic [7:0]  pixel_out,
  output logic        underflow,
  output logic [31:0] p_wb_ADR_O,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [2:0]  fetch_state
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = $clog2(PIX_DIV);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int WPB     = BLOCK_SIZE / 4;
  localparam int WCW     = $clog2(WPB) + 1;

  localparam logic [HW-1:0]  H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT       = HW'(H_ACTIVE);
  localparam logic [VW-1:0]  V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT       = VW'(V_ACTIVE);
  localparam logic [DW-1:0]  DIV_LAST    = DW'(PIX_DIV - 1);
  localparam logic [WCW-1:0] WORD_LAST   = WCW'(WPB - 1);
  localparam logic [PW:0]    PREFILL     = (PW+1)'(BLOCK_SIZE);
  localparam logic [PW:0]    SPACE_LIMIT = (PW+1)'(FIFO_DEPTH - BLOCK_SIZE);
  localparam logic [31:0]    FRAME_BYTES = 32'(H_ACTIVE * V_ACTIVE);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SPACE = 3'd2;
  localparam logic [2:0] ST_REQ   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // ---------------------------------------------------------------------------
  // Pending base register
  // ---------------------------------------------------------------------------
  logic [31:0] pend_base;
  logic        pend_valid;

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      pend_base  <= '0;
      pend_valid <= 1'b0;
    end else if (frame_base_valid) begin
      pend_base  <= frame_base;
      pend_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO: one extra pointer bit separates full from empty
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wptr, rptr;
  logic [PW:0] fifo_count;
  logic        fifo_empty;
  logic        push, pop;
  logic [31:0] push_data;

  assign fifo_count = wptr - rptr;
  assign fifo_empty = (wptr == rptr);

  always_ff @(posedge p_clk) begin
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        mem[wptr[PW-1:0] + PW'(i)] <= push_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(4);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  logic [2:0]     state;
  logic [31:0]    addr;
  logic [31:0]    bytes_fetched;
  logic [WCW-1:0] word_cnt;
  logic           bus_done;
  logic           eof;

  assign bus_done  = p_wb_ACK_I | p_wb_ERR_I;
  assign push      = (state == ST_WAIT) && bus_done;
  assign push_data = p_wb_ERR_I ? 32'd0 : p_wb_DAT_I;

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      bytes_fetched <= '0;
      word_cnt      <= '0;
    end else begin
      case (state)
        // The live strobe also counts so START sees the freshly loaded base.
        ST_IDLE: if (pend_valid || frame_base_valid) state <= ST_START;
        ST_START: begin
          addr          <= pend_base;
          bytes_fetched <= '0;
          state         <= ST_SPACE;
        end
        ST_SPACE: begin
          if (fifo_count <= SPACE_LIMIT) begin
            word_cnt <= '0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus_done) begin
            addr          <= addr + 32'd4;
            bytes_fetched <= bytes_fetched + 32'd4;
            word_cnt      <= word_cnt + WCW'(1);
            if (word_cnt == WORD_LAST) begin
              state <= (bytes_fetched + 32'd4 == FRAME_BYTES) ? ST_DONE : ST_SPACE;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_DONE: if (eof) state <= ST_START;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from the state register, so reset drops them without a clock.
  assign p_wb_CYC_O  = (state == ST_REQ) || (state == ST_WAIT);
  assign p_wb_STB_O  = p_wb_CYC_O;
  assign p_wb_ADR_O  = addr;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign fetch_state = state;

  // ---------------------------------------------------------------------------
  // Timing generator
  // ---------------------------------------------------------------------------
  logic          run;
  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          slot_tick;
  logic          slot_active;

  assign slot_tick   = run && (div == DIV_LAST);
  assign slot_active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign eof         = slot_tick && (hcnt == H_LAST) && (vcnt == V_LAST);
  assign pop         = slot_tick && slot_active && !fifo_empty;

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      run         <= 1'b0;
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      pixel_out   <= '0;
      underflow   <= 1'b0;
    end else begin
      underflow <= 1'b0;
      // Once prefilled the raster never stops, even if the FIFO later drains.
      if (!run && (fifo_count >= PREFILL)) run <= 1'b1;
      if (run) div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (slot_tick) begin
        frame_valid <= (vcnt < V_ACT);
        line_valid  <= slot_active;
        pixel_out   <= (slot_active && !fifo_empty) ? mem[rptr[PW-1:0]] : 8'd0;
        underflow   <= slot_active && fifo_empty;
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_out_reader.sv
module tb_video_out_reader;

  localparam int H_ACTIVE   = 8;
  localparam int V_ACTIVE   = 2;
  localparam int H_BLANK    = 4;
  localparam int V_BLANK    = 1;
  localparam int PIX_DIV    = 2;
  localparam int BLOCK_SIZE = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int HT         = H_ACTIVE + H_BLANK;
  localparam int VT         = V_ACTIVE + V_BLANK;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / 4;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic        p_clk = 1'b0;
  logic        p_reset = 1'b1;
  logic [31:0] frame_base = '0;
  logic        frame_base_valid = 1'b0;
  logic        frame_valid, line_valid, underflow;
  logic [7:0]  pixel_out;
  logic [31:0] p_wb_ADR_O, p_wb_DAT_I;
  logic        wb_ack, wb_err;
  logic        p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O;
  logic [3:0]  p_wb_SEL_O;
  logic [2:0]  fetch_state;

  always #5 p_clk = ~p_clk;

  video_out_reader #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK),
    .PIX_DIV(PIX_DIV), .BLOCK_SIZE(BLOCK_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .frame_base(frame_base), .frame_base_valid(frame_base_valid),
    .frame_valid(frame_valid), .line_valid(line_valid),
    .pixel_out(pixel_out), .underflow(underflow),
    .p_wb_ADR_O(p_wb_ADR_O), .p_wb_DAT_I(p_wb_DAT_I),
    .p_wb_ACK_I(wb_ack), .p_wb_ERR_I(wb_err),
    .p_wb_CYC_O(p_wb_CYC_O), .p_wb_STB_O(p_wb_STB_O),
    .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O),
    .fetch_state(fetch_state)
  );

  // ---------------------------------------------------------------------------
  // RAM slave model
  // ---------------------------------------------------------------------------
  logic [7:0]  salt = '0;
  bit          bo_mode = 1'b0;
  logic [31:0] bo_addr = '0;
  int          max_dly = 0;
  bit          dly_random = 1'b0;
  int          err_word = -1;
  int          both_word = -1;
  int          dly_cnt, dly_tgt, wb_words;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [7:0] b;
    if (bo_mode && a == bo_addr) return 32'h44332211;
    b = a[7:0] + a[23:16] + salt;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic int pick_dly();
    return dly_random ? int'($urandom_range(0, max_dly)) : max_dly;
  endfunction

  assign p_wb_DAT_I = ram_word(p_wb_ADR_O);

  always @(posedge p_clk) begin
    if (p_reset) begin
      wb_ack <= 1'b0; wb_err <= 1'b0; dly_cnt <= 0; wb_words <= 0; dly_tgt <= pick_dly();
    end else if (wb_ack || wb_err) begin
      wb_ack <= 1'b0; wb_err <= 1'b0; dly_cnt <= 0;
    end else if (p_wb_CYC_O && p_wb_STB_O) begin
      if (dly_cnt >= dly_tgt) begin
        wb_err   <= (wb_words == err_word) || (wb_words == both_word);
        wb_ack   <= (wb_words != err_word);
        wb_words <= wb_words + 1;
        dly_tgt  <= pick_dly();
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model_base = '0;
  logic [31:0] watch_addr = '0;
  bit          saw_watch = 1'b0;
  int          dut_uf_cnt = 0;
  int          mdl_uf_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Raster position is pure arithmetic on cycles since the model saw prefill;
  // the byte stream is the RAM contents at the addresses a frame should visit.
  always @(negedge p_clk) begin : model
    bit          m_run;
    int          m_tcnt, m_w, slot, h, v;
    logic [31:0] m_frame_base, ea, wd;
    bit          e_fv, e_lv, e_uf;
    logic [7:0]  e_pix;
    if (p_reset) begin
      exp_q.delete();
      m_run = 0; m_tcnt = 0; m_w = 0;
      e_fv = 0; e_lv = 0; e_uf = 0; e_pix = '0;
    end else begin
      check("frame_valid", frame_valid, e_fv);
      check("line_valid", line_valid, e_lv);
      check("underflow", underflow, e_uf);
      if (e_lv) check("pixel_out", pixel_out, e_pix);
      if (underflow === 1'b1) dut_uf_cnt++;
      ea = '0;
      if (wb_ack || wb_err) begin
        if (m_w == 0) m_frame_base = model_base;
        ea = m_frame_base + 32'(4 * m_w);
        check("wb_adr", p_wb_ADR_O, ea);
        check("wb_cyc_stb", {p_wb_CYC_O, p_wb_STB_O}, 2'b11);
        if (p_wb_ADR_O == watch_addr) saw_watch = 1'b1;
      end
      e_uf = 0;
      if (m_run) begin
        if (m_tcnt % PIX_DIV == PIX_DIV - 1) begin
          slot = m_tcnt / PIX_DIV;
          h = slot % HT;
          v = (slot / HT) % VT;
          e_fv = (v < V_ACTIVE);
          e_lv = (h < H_ACTIVE) && (v < V_ACTIVE);
          e_pix = '0;
          if (e_lv) begin
            if (exp_q.size() == 0) begin
              e_uf = 1; mdl_uf_cnt++;
            end else begin
              e_pix = exp_q.pop_front();
            end
          end
        end
        m_tcnt++;
      end else if (exp_q.size() >= BLOCK_SIZE) begin
        m_run = 1; m_tcnt = 0;
      end
      if (wb_ack || wb_err) begin
        wd = wb_err ? 32'd0 : ram_word(ea);
        for (int i = 0; i < 4; i++) exp_q.push_back(wd[8*i +: 8]);
        m_w = (m_w + 1) % FRAME_WORDS;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    p_reset = 1'b1;
    dut_uf_cnt = 0; mdl_uf_cnt = 0; saw_watch = 1'b0;
    repeat (3) @(posedge p_clk);
    #1 p_reset = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] base);
    @(negedge p_clk);
    frame_base = base; frame_base_valid = 1'b1; model_base = base;
    @(negedge p_clk);
    frame_base_valid = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge p_clk);
  endtask

  task automatic wait_line_valid(input int limit);
    int n = 0;
    while (line_valid !== 1'b1 && n < limit) begin @(negedge p_clk); n++; end
    check("line_valid_seen", line_valid, 1'b1);
  endtask

  task automatic wait_cyc(input int limit);
    int n = 0;
    while (p_wb_CYC_O !== 1'b1 && n < limit) begin @(negedge p_clk); n++; end
    check("cyc_seen", p_wb_CYC_O, 1'b1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (fetch_state !== 3'd5 && n < limit) begin @(negedge p_clk); n++; end
    check("fetch_done_seen", fetch_state, 3'd5);
  endtask

  task automatic setup(input logic [7:0] s, input int md, input bit rnd);
    salt = s; max_dly = md; dly_random = rnd;
    bo_mode = 1'b0; err_word = -1; both_word = -1; watch_addr = 32'hFFFF_FFFF;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] b;
    setup(8'h00, 0, 1'b0);
    do_reset();
    @(negedge p_clk);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_pixel", pixel_out, 8'h00);
    check("rst_underflow", underflow, 1'b0);
    check("rst_cyc_stb", {p_wb_CYC_O, p_wb_STB_O}, 2'b00);
    check("rst_adr", p_wb_ADR_O, 32'h0);
    check("rst_we", p_wb_WE_O, 1'b0);
    check("rst_sel", p_wb_SEL_O, 4'hF);
    check("rst_state_idle", fetch_state, 3'd0);

    // Prefill and first frames, zero-wait RAM holding 0x00..0x0F.
    strobe(32'h4100_0000);
    wait_line_valid(200);
    check("first_pixel", pixel_out, 8'h00);
    run_cycles(250);

    // Byte order within a word.
    setup(8'($urandom_range(0, 255)), 0, 1'b0);
    bo_mode = 1'b1; bo_addr = 32'h4100_0040;
    do_reset();
    strobe(32'h4100_0040);
    wait_line_valid(200);
    check("byte0", pixel_out, 8'h11);
    repeat (PIX_DIV) @(negedge p_clk);
    check("byte1", pixel_out, 8'h22);
    repeat (PIX_DIV) @(negedge p_clk);
    check("byte2", pixel_out, 8'h33);
    repeat (PIX_DIV) @(negedge p_clk);
    check("byte3", pixel_out, 8'h44);
    run_cycles(60);

    // Back-pressure: every word acknowledged 10 cycles late.
    setup(8'($urandom_range(0, 255)), 10, 1'b0);
    do_reset();
    strobe(32'h4100_0000);
    run_cycles(600);
    check("uf_seen", dut_uf_cnt > 0, 1'b1);
    check("uf_count", dut_uf_cnt, mdl_uf_cnt);

    // Base change while a frame is in flight.
    setup(8'($urandom_range(0, 255)), 2, 1'b1);
    watch_addr = 32'h4110_0000;
    do_reset();
    strobe(32'h4100_0000);
    wait_done(200);
    strobe(32'h4110_0000);
    run_cycles(250);
    check("new_base_fetched", saw_watch, 1'b1);

    // Error on word 1; ACK and ERR together on word 6.
    setup(8'($urandom_range(0, 255)), 1, 1'b1);
    err_word = 1; both_word = 6;
    do_reset();
    strobe(32'h4120_0100);
    run_cycles(250);

    // Reset in the middle of a burst.
    setup(8'($urandom_range(0, 255)), 10, 1'b0);
    do_reset();
    strobe(32'h4100_0000);
    wait_cyc(100);
    @(posedge p_clk);
    #1 p_reset = 1'b1;
    #1;
    check("mid_rst_cyc_stb", {p_wb_CYC_O, p_wb_STB_O}, 2'b00);
    check("mid_rst_adr", p_wb_ADR_O, 32'h0);
    check("mid_rst_state", fetch_state, 3'd0);
    check("mid_rst_outs", {frame_valid, line_valid, underflow, pixel_out}, 11'h0);
    repeat (3) @(posedge p_clk);
    #1 p_reset = 1'b0;
    repeat (20) @(negedge p_clk);
    check("post_rst_idle", fetch_state, 3'd0);
    check("post_rst_cyc", p_wb_CYC_O, 1'b0);
    max_dly = 0;
    strobe(32'h4130_0000);
    run_cycles(200);

    // Randomised bases, salts and wait states.
    for (int t = 0; t < 3; t++) begin
      setup(8'($urandom_range(0, 255)), 3, 1'b1);
      do_reset();
      b = 32'h4000_0000 | ($urandom & 32'h00FF_FFFC);
      strobe(b);
      wait_done(400);
      b = 32'h4000_0000 | ($urandom & 32'h00FF_FFFC);
      strobe(b);
      run_cycles(350);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
